// File: rtl/seq_pattern_tx_pkg.sv
// Shared definitions for the serial pattern transmitter: FSM states,
// default parameter values and a counter-width helper.
package seq_pattern_tx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_e;

   localparam int   DEF_MAX_LEN    = 16;
   localparam int   DEF_LEN_W      = 5;
   localparam int   DEF_REP_W      = 4;
   localparam int   DEF_GAP_CYCLES = 1;
   localparam logic DEF_IDLE_LEVEL = 1'b0;

   // Gap counter only needs to hold GAP_CYCLES-1; keep at least one bit.
   function automatic int gap_cnt_width(input int gap);
      return (gap > 1) ? $clog2(gap) : 1;
   endfunction

endpackage

// File: rtl/seq_down_cnt.sv
// Loadable down counter with a zero flag; saturates at zero instead of wrapping.
module seq_down_cnt #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial bit-pattern transmitter: shifts a captured pattern out MSB-first,
// repeat_n times with optional idle gaps, then pulses done.
module seq_pattern_tx
   import seq_pattern_tx_pkg::*;
#(
   parameter int   MAX_LEN    = DEF_MAX_LEN,
   parameter int   LEN_W      = DEF_LEN_W,
   parameter int   REP_W      = DEF_REP_W,
   parameter int   GAP_CYCLES = DEF_GAP_CYCLES,
   parameter logic IDLE_LEVEL = DEF_IDLE_LEVEL
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               abort,
   input  logic [MAX_LEN-1:0] pattern,
   input  logic [LEN_W-1:0]   len,
   input  logic [REP_W-1:0]   repeat_n,
   output logic               x,
   output logic               x_valid,
   output logic               busy,
   output logic               done
);

   localparam int GAP_W    = gap_cnt_width(GAP_CYCLES);
   localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

   state_e             state_q, state_d;
   logic [MAX_LEN-1:0] pat_q, pat_d;
   logic [MAX_LEN-1:0] shift_q, shift_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic               x_q, x_d;
   logic               x_valid_q, x_valid_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic               bit_load, bit_dec, bit_zero;
   logic [LEN_W-1:0]   bit_load_val;
   logic               rep_load, rep_dec, rep_zero;
   logic [REP_W-1:0]   rep_load_val;
   logic               gap_load, gap_dec, gap_zero;

   logic [MAX_LEN-1:0] aligned;
   logic               job_legal;

   // Left-align the pattern so the first bit to send always sits in the MSB.
   assign aligned   = pattern << (LEN_W'(MAX_LEN) - len);
   assign job_legal = (len != '0) && (len <= LEN_W'(MAX_LEN)) && (repeat_n != '0);
   assign rep_load_val = repeat_n - 1'b1;

   always_comb begin
      state_d      = state_q;
      pat_d        = pat_q;
      shift_d      = shift_q;
      len_d        = len_q;
      x_d          = IDLE_LEVEL;
      x_valid_d    = 1'b0;
      busy_d       = 1'b0;
      done_d       = 1'b0;
      bit_load     = 1'b0;
      bit_dec      = 1'b0;
      bit_load_val = len_q - 1'b1;
      rep_load     = 1'b0;
      rep_dec      = 1'b0;
      gap_load     = 1'b0;
      gap_dec      = 1'b0;

      if (abort) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start && job_legal) begin
                  state_d      = ST_SHIFT;
                  pat_d        = aligned;
                  shift_d      = aligned << 1;
                  len_d        = len;
                  x_d          = aligned[MAX_LEN-1];
                  x_valid_d    = 1'b1;
                  busy_d       = 1'b1;
                  bit_load     = 1'b1;
                  bit_load_val = len - 1'b1;
                  rep_load     = 1'b1;
               end
            end
            // Bit counter holds the number of bits still to follow the one on x.
            ST_SHIFT: begin
               if (!bit_zero) begin
                  bit_dec   = 1'b1;
                  x_d       = shift_q[MAX_LEN-1];
                  shift_d   = shift_q << 1;
                  x_valid_d = 1'b1;
                  busy_d    = 1'b1;
               end else if (!rep_zero) begin
                  rep_dec = 1'b1;
                  busy_d  = 1'b1;
                  if (GAP_CYCLES > 0) begin
                     state_d  = ST_GAP;
                     gap_load = 1'b1;
                  end else begin
                     bit_load  = 1'b1;
                     x_d       = pat_q[MAX_LEN-1];
                     shift_d   = pat_q << 1;
                     x_valid_d = 1'b1;
                  end
               end else begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end
            end
            ST_GAP: begin
               busy_d = 1'b1;
               if (gap_zero) begin
                  state_d   = ST_SHIFT;
                  bit_load  = 1'b1;
                  x_d       = pat_q[MAX_LEN-1];
                  shift_d   = pat_q << 1;
                  x_valid_d = 1'b1;
               end else begin
                  gap_dec = 1'b1;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         pat_q     <= '0;
         shift_q   <= '0;
         len_q     <= '0;
         x_q       <= IDLE_LEVEL;
         x_valid_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pat_q     <= pat_d;
         shift_q   <= shift_d;
         len_q     <= len_d;
         x_q       <= x_d;
         x_valid_q <= x_valid_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   seq_down_cnt #(.W(LEN_W)) u_bit_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (bit_load),
      .load_val (bit_load_val),
      .dec      (bit_dec),
      .zero     (bit_zero)
   );

   seq_down_cnt #(.W(REP_W)) u_rep_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (rep_load),
      .load_val (rep_load_val),
      .dec      (rep_dec),
      .zero     (rep_zero)
   );

   seq_down_cnt #(.W(GAP_W)) u_gap_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (gap_load),
      .load_val (GAP_W'(GAP_LOAD)),
      .dec      (gap_dec),
      .zero     (gap_zero)
   );

   assign x       = x_q;
   assign x_valid = x_valid_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx: per-cycle scoreboard of expected
// line values plus a table of jobs with expected busy/done/detector counts.
module tb_seq_pattern_tx;

   localparam int MAX_LEN = 16;
   localparam int GAP     = 1;

   typedef struct packed {
      logic x;
      logic xv;
      logic busy;
      logic done;
   } out_t;

   typedef struct {
      logic [15:0] pattern;
      logic [4:0]  len;
      logic [3:0]  rep;
      int          exp_busy;
      int          exp_done;
      int          exp_det;
   } job_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        abort;
   logic [15:0] pattern;
   logic [4:0]  len;
   logic [3:0]  repeat_n;
   logic        x, x_valid, busy, done;

   int   checks = 0;
   int   errors = 0;
   int   busy_cycles;
   int   done_count;
   int   det_count;
   logic [2:0] det_hist;
   out_t exp_q[$];
   job_t jobs[9];

   seq_pattern_tx #(
      .MAX_LEN    (16),
      .LEN_W      (5),
      .REP_W      (4),
      .GAP_CYCLES (GAP),
      .IDLE_LEVEL (1'b0)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .abort    (abort),
      .pattern  (pattern),
      .len      (len),
      .repeat_n (repeat_n),
      .x        (x),
      .x_valid  (x_valid),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   function automatic out_t actualOut();
      return out_t'({x, x_valid, busy, done});
   endfunction

   task automatic checkOutput(input string name, input out_t act, input out_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got x=%b xv=%b busy=%b done=%b, want x=%b xv=%b busy=%b done=%b",
                  name, act.x, act.xv, act.busy, act.done, exp.x, exp.xv, exp.busy, exp.done);
      end
   endtask

   task automatic checkCount(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   task automatic pushJob(input logic [15:0] p, input int l, input int r);
      for (int k = 0; k < r; k++) begin
         if (k > 0) begin
            for (int g = 0; g < GAP; g++) exp_q.push_back(out_t'(4'b0010));
         end
         for (int i = l - 1; i >= 0; i--) exp_q.push_back(out_t'({p[4'(i)], 3'b110}));
      end
      exp_q.push_back(out_t'(4'b0001));
   endtask

   // Drive one cycle of inputs, let one edge pass, compare against the scoreboard.
   task automatic applyStimulus(input logic s, input logic a, input logic [15:0] p,
                                input logic [4:0] l, input logic [3:0] r, input string name);
      logic legal;
      out_t exp;
      start = s; abort = a; pattern = p; len = l; repeat_n = r;
      legal = (l != 0) && (l <= 5'(MAX_LEN)) && (r != 0);
      if (a) exp_q.delete();
      else if (s && legal && exp_q.size() == 0) pushJob(p, int'(l), int'(r));
      @(posedge clk);
      #1;
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : out_t'(4'b0000);
      checkOutput(name, actualOut(), exp);
      if (busy === 1'b1) busy_cycles++;
      if (done === 1'b1) done_count++;
      if (x_valid === 1'b1) begin
         det_hist = {det_hist[1:0], x};
         if (det_hist == 3'b101) det_count++;
      end
      start = 1'b0;
      abort = 1'b0;
   endtask

   task automatic idleSteps(input int n, input string name);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 16'h0000, 5'd0, 4'd0, name);
   endtask

   task automatic clearCounts();
      busy_cycles = 0;
      done_count  = 0;
      det_count   = 0;
      det_hist    = 3'b000;
   endtask

   initial begin
      jobs[0] = '{16'h0005, 5'd3,  4'd1,  3,  1, 1};
      jobs[1] = '{16'h0005, 5'd3,  4'd2,  7,  1, 2};
      jobs[2] = '{16'hA5F0, 5'd16, 4'd1,  16, 1, 2};
      jobs[3] = '{16'h0001, 5'd1,  4'd3,  5,  1, -1};
      jobs[4] = '{16'h0005, 5'd0,  4'd1,  0,  0, 0};
      jobs[5] = '{16'h0005, 5'd3,  4'd0,  0,  0, 0};
      jobs[6] = '{16'hFFFF, 5'd17, 4'd1,  0,  0, 0};
      jobs[7] = '{16'h0003, 5'd2,  4'd15, 44, 1, -1};
      jobs[8] = '{16'h8001, 5'd16, 4'd2,  33, 1, -1};

      reset = 1'b0; start = 1'b0; abort = 1'b0;
      pattern = '0; len = '0; repeat_n = '0;
      clearCounts();
      #12;
      checkOutput("reset_values", actualOut(), out_t'(4'b0000));
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;

      foreach (jobs[j]) begin
         clearCounts();
         applyStimulus(1'b1, 1'b0, jobs[j].pattern, jobs[j].len, jobs[j].rep, $sformatf("job%0d_start", j));
         idleSteps(50, $sformatf("job%0d_run", j));
         checkCount($sformatf("job%0d_busy_cycles", j), busy_cycles, jobs[j].exp_busy);
         checkCount($sformatf("job%0d_done_pulses", j), done_count, jobs[j].exp_done);
         if (jobs[j].exp_det >= 0)
            checkCount($sformatf("job%0d_det101", j), det_count, jobs[j].exp_det);
      end

      // Start pulsed while busy (at bit 5) must not disturb the running job.
      applyStimulus(1'b1, 1'b0, 16'hA5F0, 5'd16, 4'd1, "t3_start");
      idleSteps(4, "t3_bits");
      applyStimulus(1'b1, 1'b0, 16'hFFFF, 5'd4, 4'd3, "t3_start_while_busy");
      idleSteps(14, "t3_tail");

      // Abort on the second bit: line idles next cycle, no done pulse.
      clearCounts();
      applyStimulus(1'b1, 1'b0, 16'h0005, 5'd3, 4'd2, "t5_start");
      idleSteps(1, "t5_bit2");
      applyStimulus(1'b0, 1'b1, 16'h0000, 5'd0, 4'd0, "t5_abort");
      idleSteps(8, "t5_after_abort");
      checkCount("t5_no_done", done_count, 0);
      applyStimulus(1'b1, 1'b1, 16'h0005, 5'd3, 4'd1, "t5_abort_and_start");
      idleSteps(3, "t5_abort_start_idle");
      applyStimulus(1'b1, 1'b0, 16'h0005, 5'd3, 4'd1, "t5_restart");
      idleSteps(5, "t5_restart_run");

      // Async reset during the gap returns outputs to reset values at once.
      clearCounts();
      applyStimulus(1'b1, 1'b0, 16'h0005, 5'd3, 4'd2, "t6_start");
      idleSteps(3, "t6_to_gap");
      #2;
      reset = 1'b0;
      #1;
      checkOutput("t6_async_reset", actualOut(), out_t'(4'b0000));
      exp_q.delete();
      @(negedge clk);
      reset = 1'b1;
      idleSteps(2, "t6_after_reset");
      checkCount("t6_no_done", done_count, 0);

      // Start in the done cycle: exactly one idle cycle between jobs.
      applyStimulus(1'b1, 1'b0, 16'h0005, 5'd3, 4'd1, "t6_job_a");
      idleSteps(3, "t6_job_a_run");
      checkCount("t6_done_seen", done_count, 1);
      applyStimulus(1'b1, 1'b0, 16'h0006, 5'd3, 4'd1, "t6_job_b_in_done_cycle");
      idleSteps(5, "t6_job_b_run");
      checkCount("t6_two_dones", done_count, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
